// File: rtl/tc_sram_rr_arbiter.sv
// Round-robin share of one single-port SRAM port among NumReq requesters; grant is combinational.
// Responses return SramLatency cycles after the grant, in grant order, and cannot be backpressured.
module tc_sram_rr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned SramLatency = 1,
  parameter int unsigned AddrWidth   = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth,
  parameter int unsigned IdxWidth    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0]                  req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]     req_be_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  output logic [DataWidth-1:0]               rsp_rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic [DataWidth-1:0]               mem_wdata_o,
  output logic [BeWidth-1:0]                 mem_be_o,
  input  logic [DataWidth-1:0]               mem_rdata_i
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] winner;
  logic                grant;
  logic [IdxWidth-1:0] cand_idx;
  int unsigned         cand;

  // Search starts at ptr_q and wraps; the first valid requester wins.
  always_comb begin
    winner   = '0;
    grant    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = cand[IdxWidth-1:0];
      if (!grant && req_valid_i[cand_idx]) begin
        winner = cand_idx;
        grant  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[winner] = 1'b1;
  end

  assign mem_req_o = |req_valid_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (grant) begin
      mem_we_o    = req_we_i[winner];
      mem_addr_o  = req_addr_i[winner];
      mem_wdata_o = req_wdata_i[winner];
      mem_be_o    = req_be_i[winner];
    end
  end

  generate
    if (NumReq == 1) begin : g_single
      assign ptr_q = '0;
    end else begin : g_ptr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ptr_q <= '0;
        end else if (grant) begin
          ptr_q <= (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
        end
      end
    end
  endgenerate

  logic                out_vld;
  logic                out_rd;
  logic [IdxWidth-1:0] out_idx;

  generate
    if (SramLatency == 0) begin : g_comb_rsp
      assign out_vld = grant;
      assign out_idx = winner;
      assign out_rd  = grant & ~mem_we_o;
    end else begin : g_pipe_rsp
      logic [SramLatency-1:0] vld_q;
      logic [SramLatency-1:0] rd_q;
      logic [IdxWidth-1:0]    idx_q [SramLatency];

      // Tracks each grant alongside the macro so the data lands at its issuer.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_q <= '0;
          rd_q  <= '0;
          for (int s = 0; s < int'(SramLatency); s++) idx_q[s] <= '0;
        end else begin
          vld_q[0] <= grant;
          rd_q[0]  <= grant & ~mem_we_o;
          idx_q[0] <= winner;
          for (int s = 1; s < int'(SramLatency); s++) begin
            vld_q[s] <= vld_q[s-1];
            rd_q[s]  <= rd_q[s-1];
            idx_q[s] <= idx_q[s-1];
          end
        end
      end

      assign out_vld = vld_q[SramLatency-1];
      assign out_rd  = rd_q[SramLatency-1];
      assign out_idx = idx_q[SramLatency-1];
    end
  endgenerate

  always_comb begin
    rsp_valid_o = '0;
    if (out_vld) rsp_valid_o[out_idx] = 1'b1;
  end

  // Write acks and idle cycles return zero so stale macro output never leaks.
  assign rsp_rdata_o = (out_vld && out_rd) ? mem_rdata_i : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(req_ready_o));
      assert ((req_ready_o & ~req_valid_i) == '0);
      assert ($onehot0(rsp_valid_o));
    end
  end
`endif

endmodule

// File: tb/tb_tc_sram_rr_arbiter.sv
// Randomized bench: behavioural SRAM plus a queue-based reference of grants and responses.
module tb_tc_sram_rr_arbiter;
  localparam int NR = 4;
  localparam int L  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NW = 1024;

  logic                  clk;
  logic                  rst_n;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0]         req_we;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [NR-1:0][BW-1:0] req_be;
  logic [NR-1:0]         rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [BW-1:0]         mem_be;
  logic [DW-1:0]         mem_rdata;

  tc_sram_rr_arbiter #(
    .NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .SramLatency(L)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural single-port SRAM with fixed read latency L.
  logic          mem_init;
  logic [DW-1:0] sram    [NW];
  logic [DW-1:0] rd_pipe [L];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) sram[i] <= init_word(i);
    end else if (mem_req && mem_we) begin
      for (int b = 0; b < BW; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    for (int s = L - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
    rd_pipe[0] <= (mem_req && !mem_we) ? sram[mem_addr] : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rd_pipe[L-1];

  typedef struct {
    int            due;
    int            idx;
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NW];
  int            mptr;
  int            cyc;
  int            checks;
  int            failures;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next one.
  task automatic drive_cycle(input logic [NR-1:0] vmask, input int vpct, input int wpct);
    int            w;
    int            c;
    logic [NR-1:0] er;
    logic [63:0]   eb;
    logic [NR-1:0] ev;
    logic [DW-1:0] ed;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = vmask[i] && ($urandom_range(0, 99) < vpct);
      req_we[i]    = ($urandom_range(0, 99) < wpct);
      req_addr[i]  = AW'($urandom_range(0, 15));
      req_wdata[i] = $urandom;
      req_be[i]    = BW'($urandom);
    end
    #1;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      c = (mptr + k) % NR;
      if (w < 0 && req_valid[c]) w = c;
    end
    er = '0;
    eb = '0;
    if (w >= 0) begin
      er[w] = 1'b1;
      eb = 64'({req_we[w], req_addr[w], req_wdata[w], req_be[w]});
    end
    check_val("req_ready", 64'(req_ready), 64'(er));
    check_val("mem_req", 64'(mem_req), 64'(w >= 0));
    check_val("mem_bus", 64'({mem_we, mem_addr, mem_wdata, mem_be}), eb);

    ev = '0;
    ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev[exp_q[0].idx] = 1'b1;
      ed = exp_q[0].rd ? exp_q[0].data : '0;
      void'(exp_q.pop_front());
    end
    check_val("rsp_valid", 64'(rsp_valid), 64'(ev));
    check_val("rsp_rdata", 64'(rsp_rdata), 64'(ed));

    if (w >= 0) begin
      exp_q.push_back('{due: cyc + L, idx: w, rd: !req_we[w], data: ref_mem[req_addr[w]]});
      if (req_we[w])
        for (int b = 0; b < BW; b++)
          if (req_be[w][b]) ref_mem[req_addr[w]][b*8 +: 8] = req_wdata[w][b*8 +: 8];
      mptr = (w + 1) % NR;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_val("rst_mem_req", 64'(mem_req), 64'd0);
    exp_q.delete();
    mptr = 0;
    repeat (3) @(posedge clk);
    #1;
    cyc  += 3;
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    mptr      = 0;
    rst_n     = 1'b0;
    mem_init  = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    reset_pulse();

    repeat (300) drive_cycle(4'b1111, 50, 40);
    repeat (40)  drive_cycle(4'b1111, 100, 30);
    repeat (60)  drive_cycle(4'b1010, 100, 30);
    repeat (60)  drive_cycle(4'b1011, 60, 30);
    repeat (80)  drive_cycle(4'b1111, 100, 0);

    // Reads left in flight across a mid-run reset must never answer.
    drive_cycle(4'b0110, 100, 0);
    drive_cycle(4'b0110, 100, 0);
    reset_pulse();
    repeat (4)   drive_cycle(4'b1100, 100, 20);
    repeat (300) drive_cycle(4'b1111, 70, 50);
    repeat (L + 2) drive_cycle(4'b0000, 0, 0);

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
